// File: rtl/ahb_ram_responder_pkg.sv
// Shared AHB-Lite encodings, responder FSM states and byte-lane helpers
// for the tightly-coupled data RAM responder.
package ahb_ram_responder_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   localparam logic [2:0] HSIZE_BYTE = 3'd0;
   localparam logic [2:0] HSIZE_HALF = 3'd1;
   localparam logic [2:0] HSIZE_WORD = 3'd2;

   typedef enum logic [2:0] {
      AR_IDLE,
      AR_WAIT,
      AR_DATA,
      AR_ERR1,
      AR_ERR2
   } ahb_resp_state_e;

   function automatic logic [3:0] ahb_byte_en(input logic [2:0] size, input logic [1:0] off);
      logic [3:0] be;
      case (size)
         HSIZE_BYTE: be = 4'b0001 << off;
         HSIZE_HALF: be = 4'b0011 << off;
         default:    be = 4'b1111;
      endcase
      return be;
   endfunction

endpackage

// File: rtl/ahb_ram_responder_if.sv
// AHB-Lite bus bundle between a single master and the RAM responder.
interface ahb_ram_responder_if;

   logic        hsel;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [2:0]  hburst;
   logic [3:0]  hprot;
   logic        hmastlock;
   logic        hready;
   logic [31:0] hwdata;
   logic [31:0] hrdata;
   logic        hreadyout;
   logic        hresp;

   modport master (
      output hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hmastlock, hready, hwdata,
      input  hrdata, hreadyout, hresp
   );

   modport slave (
      input  hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hmastlock, hready, hwdata,
      output hrdata, hreadyout, hresp
   );

endinterface

// File: rtl/ahb_ram_responder_sram.sv
// Word-organised RAM built from four byte-lane arrays, each with its own
// write enable and a registered read port (old data on read/write collision).
module ahb_sram_array #(
   parameter int DEPTH = 1024,
   parameter int AW    = 10
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [3:0]    be_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [31:0]   wdata_i,
   input  logic          re_i,
   input  logic [AW-1:0] raddr_i,
   output logic [31:0]   rdata_o
);

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] lane_mem [DEPTH];
         logic [7:0] rd_q;

         always_ff @(posedge clk_i) begin
            if (we_i && be_i[gi]) begin
               lane_mem[waddr_i] <= wdata_i[8*gi +: 8];
            end
            if (re_i) begin
               rd_q <= lane_mem[raddr_i];
            end
         end

         assign rdata_o[8*gi +: 8] = rd_q;
      end
   endgenerate

endmodule

// File: rtl/ahb_ram_responder.sv
// AHB-Lite responder fronting a local data RAM: optional wait states, two-cycle
// ERROR for bad accesses, and a bypass for a read that overlaps a finishing write.
module ahb_ram_responder
   import ahb_ram_responder_pkg::*;
#(
   parameter int          MEM_BYTES   = 4096,
   parameter logic [31:0] BASE_ADDR   = 32'h0,
   parameter int          WAIT_STATES = 0
) (
   input logic                 s_clk_i,
   input logic                 s_reset_i,
   ahb_ram_responder_if.slave  s
);

   localparam int          DEPTH       = MEM_BYTES / 4;
   localparam int          AW          = $clog2(DEPTH);
   localparam logic [31:0] MEM_BYTES_W = 32'(MEM_BYTES);

   ahb_resp_state_e state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic [AW-1:0]   waddr_q, waddr_d;
   logic [1:0]      off_q, off_d;
   logic [2:0]      size_q, size_d;
   logic            write_q, write_d;
   logic            byp_q, byp_d;
   logic [31:0]     byp_data_q, byp_data_d;
   logic [3:0]      byp_be_q, byp_be_d;

   logic [31:0]     offset;
   logic [AW-1:0]   acc_word;
   logic            addr_err;
   logic            take;
   logic            wr_commit;
   logic [3:0]      be_cur;
   logic [31:0]     ram_rdata;
   logic [31:0]     merged;
   logic            unused_ok;

   assign offset   = s.haddr - BASE_ADDR;
   assign acc_word = offset[AW+1:2];
   // Unsigned offset also catches addresses below the base.
   assign addr_err = (offset >= MEM_BYTES_W) || (s.hsize > HSIZE_WORD) ||
                     (s.hsize == HSIZE_WORD && s.haddr[1:0] != 2'b00) ||
                     (s.hsize == HSIZE_HALF && s.haddr[0]);
   assign take     = s.hsel && !(s.htrans inside {HTRANS_IDLE, HTRANS_BUSY}) && s.hready &&
                     (state_q == AR_IDLE || state_q == AR_DATA || state_q == AR_ERR2);
   assign be_cur    = ahb_byte_en(size_q, off_q);
   assign wr_commit = (state_q == AR_DATA) && write_q && !s_reset_i;
   assign unused_ok = ^{s.hburst, s.hprot, s.hmastlock};

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      waddr_d    = waddr_q;
      off_d      = off_q;
      size_d     = size_q;
      write_d    = write_q;
      byp_d      = byp_q;
      byp_data_d = byp_data_q;
      byp_be_d   = byp_be_q;
      case (state_q)
         AR_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_d = AR_DATA;
         end
         AR_ERR1: state_d = AR_ERR2;
         default: begin
            state_d = AR_IDLE;
            if (take) begin
               waddr_d    = acc_word;
               off_d      = s.haddr[1:0];
               size_d     = s.hsize;
               write_d    = s.hwrite;
               byp_d      = wr_commit && !s.hwrite && !addr_err && (acc_word == waddr_q);
               byp_data_d = s.hwdata;
               byp_be_d   = be_cur;
               if (addr_err) begin
                  state_d = AR_ERR1;
               end else if (WAIT_STATES != 0) begin
                  state_d = AR_WAIT;
                  cnt_d   = 4'(WAIT_STATES);
               end else begin
                  state_d = AR_DATA;
               end
            end
         end
      endcase
   end

   always_ff @(posedge s_clk_i) begin
      if (s_reset_i) begin
         state_q    <= AR_IDLE;
         cnt_q      <= '0;
         waddr_q    <= '0;
         off_q      <= '0;
         size_q     <= '0;
         write_q    <= 1'b0;
         byp_q      <= 1'b0;
         byp_data_q <= '0;
         byp_be_q   <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         waddr_q    <= waddr_d;
         off_q      <= off_d;
         size_q     <= size_d;
         write_q    <= write_d;
         byp_q      <= byp_d;
         byp_data_q <= byp_data_d;
         byp_be_q   <= byp_be_d;
      end
   end

   ahb_sram_array #(.DEPTH(DEPTH), .AW(AW)) u_ram (
      .clk_i   (s_clk_i),
      .we_i    (wr_commit),
      .be_i    (be_cur),
      .waddr_i (waddr_q),
      .wdata_i (s.hwdata),
      .re_i    (take && !addr_err && !s.hwrite),
      .raddr_i (acc_word),
      .rdata_o (ram_rdata)
   );

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_merge
         assign merged[8*gi +: 8] = (byp_q && byp_be_q[gi]) ? byp_data_q[8*gi +: 8]
                                                            : ram_rdata[8*gi +: 8];
      end
   endgenerate

   assign s.hreadyout = !(state_q == AR_WAIT || state_q == AR_ERR1);
   assign s.hresp     = (state_q == AR_ERR1 || state_q == AR_ERR2) ? HRESP_ERROR : HRESP_OKAY;
   assign s.hrdata    = ((state_q == AR_WAIT || state_q == AR_DATA) && !write_q) ? merged : 32'h0;

endmodule

// File: tb/tb_ahb_ram_responder.sv
// Randomised and directed check of two responders (0 and 3 wait states) against
// a transaction-level byte-array model of the RAM and AHB response rules.
module tb_ahb_ram_responder;
   import ahb_ram_responder_pkg::*;

   localparam int          MEM_BYTES = 4096;
   localparam logic [31:0] BASE0     = 32'h0000_0000;
   localparam logic [31:0] BASE3     = 32'h2000_0000;

   typedef struct {
      int          start;
      bit          err;
      bit          rd;
      int          ws;
      logic [31:0] addr;
      logic [31:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        tgt;
   logic        b_hsel, b_hwrite, b_hmastlock;
   logic [31:0] b_haddr, b_hwdata;
   logic [1:0]  b_htrans;
   logic [2:0]  b_hsize, b_hburst;
   logic [3:0]  b_hprot;

   ahb_ram_responder_if bus0();
   ahb_ram_responder_if bus3();

   assign bus0.hsel = b_hsel & ~tgt;      assign bus3.hsel = b_hsel & tgt;
   assign bus0.haddr = b_haddr;           assign bus3.haddr = b_haddr;
   assign bus0.htrans = b_htrans;         assign bus3.htrans = b_htrans;
   assign bus0.hwrite = b_hwrite;         assign bus3.hwrite = b_hwrite;
   assign bus0.hsize = b_hsize;           assign bus3.hsize = b_hsize;
   assign bus0.hburst = b_hburst;         assign bus3.hburst = b_hburst;
   assign bus0.hprot = b_hprot;           assign bus3.hprot = b_hprot;
   assign bus0.hmastlock = b_hmastlock;   assign bus3.hmastlock = b_hmastlock;
   assign bus0.hwdata = b_hwdata;         assign bus3.hwdata = b_hwdata;
   assign bus0.hready = bus0.hreadyout;   assign bus3.hready = bus3.hreadyout;

   ahb_ram_responder #(.MEM_BYTES(MEM_BYTES), .BASE_ADDR(BASE0), .WAIT_STATES(0)) dut0 (
      .s_clk_i(clk), .s_reset_i(rst), .s(bus0));
   ahb_ram_responder #(.MEM_BYTES(MEM_BYTES), .BASE_ADDR(BASE3), .WAIT_STATES(3)) dut3 (
      .s_clk_i(clk), .s_reset_i(rst), .s(bus3));

   logic [7:0]  mdl [2][MEM_BYTES];
   exp_t        expq[$];
   exp_t        cur;
   bit          active = 0;
   int          ph, lowcnt;
   int          n_chk = 0, n_fail = 0;
   logic [31:0] last_rd;
   logic        last_resp;
   int          last_low;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   function automatic logic cur_ready();
      return tgt ? bus3.hreadyout : bus0.hreadyout;
   endfunction

   function automatic logic [31:0] mdl_word(input int t, input int idx);
      return {mdl[t][idx+3], mdl[t][idx+2], mdl[t][idx+1], mdl[t][idx]};
   endfunction

   task automatic xfer(input bit w, input int sz, input logic [31:0] off,
                       input logic [31:0] wd, input bit apply);
      exp_t        e;
      int          g, idx, t;
      logic [31:0] base;
      t    = int'(tgt);
      base = tgt ? BASE3 : BASE0;
      g    = 0;
      while (!cur_ready() && g < 50) begin
         next_cycle();
         g++;
      end
      if (g >= 50) begin
         n_chk++; n_fail++;
         $display("FAIL ready_timeout: got hreadyout 0 expected 1 within 50 cycles");
      end
      b_hsel = 1'b1; b_haddr = base + off; b_hwrite = w; b_hsize = 3'(sz);
      b_htrans = ($urandom_range(1) != 0) ? HTRANS_SEQ : HTRANS_NONSEQ;
      b_hburst = 3'($urandom_range(7)); b_hprot = 4'($urandom_range(15));
      b_hmastlock = 1'($urandom_range(1));
      e.start = cyc + 1;
      e.addr  = base + off;
      e.rd    = !w;
      e.data  = 32'h0;
      // Bytes are valid only inside the window and at natural alignment for their size.
      e.err   = (off >= 32'(MEM_BYTES)) || (sz > 2) || ((off % (32'd1 << (sz % 4))) != 0);
      e.ws    = e.err ? 0 : (tgt ? 3 : 0);
      if (!e.err) begin
         idx = int'(off & ~32'd3);
         if (w) begin
            if (apply) begin
               for (int i = 0; i < 4; i++) begin
                  if (i >= int'(off[1:0]) && i < int'(off[1:0]) + (1 << sz))
                     mdl[t][idx+i] = wd[8*i +: 8];
               end
            end
         end else begin
            e.data = mdl_word(t, idx);
         end
      end
      expq.push_back(e);
      next_cycle();
      b_hsel = 1'($urandom_range(1)); b_htrans = HTRANS_IDLE; b_haddr = $urandom();
      b_hwdata = w ? wd : $urandom();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         b_hsel   = 1'($urandom_range(1));
         b_htrans = b_hsel ? (($urandom_range(1) != 0) ? HTRANS_BUSY : HTRANS_IDLE)
                           : 2'($urandom_range(3));
         b_haddr  = $urandom();
         b_hwrite = 1'($urandom_range(1));
         next_cycle();
      end
   endtask

   task automatic drain();
      int g;
      g = 0;
      while ((expq.size() != 0 || active) && g < 100) begin
         next_cycle();
         g++;
      end
      if (g >= 100) begin
         n_chk++; n_fail++;
         $display("FAIL drain_timeout: got %0d pending expected 0", expq.size());
      end
   endtask

   task automatic rand_ops(input int n);
      for (int i = 0; i < n; i++) begin
         int          r, sz;
         bit          w;
         logic [31:0] off;
         r = $urandom_range(99);
         if (r < 15) begin
            idle($urandom_range(1, 3));
         end else begin
            w  = 1'($urandom_range(1));
            sz = ($urandom_range(9) == 0) ? $urandom_range(3, 7) : $urandom_range(2);
            case ($urandom_range(19))
               0:       off = 32'h1000 + 32'($urandom_range(255));
               1:       off = 32'hFFFF_FF00 + 32'($urandom_range(255));
               2:       off = 32'hFFC;
               default: off = 32'($urandom_range(255));
            endcase
            xfer(w, sz, off, $urandom(), 1'b1);
         end
      end
   endtask

   // Compare process: every cycle, the targeted responder against the expected data phase.
   initial begin
      logic        o_rdy, o_resp, e_rdy, e_resp;
      logic [31:0] o_data, e_data;
      forever begin
         @(negedge clk);
         if (rst) begin
            active = 0;
            expq.delete();
         end else begin
            if (!active && expq.size() != 0 && expq[0].start == cyc) begin
               cur = expq.pop_front();
               active = 1; ph = 0; lowcnt = 0;
            end
            o_rdy  = tgt ? bus3.hreadyout : bus0.hreadyout;
            o_resp = tgt ? bus3.hresp : bus0.hresp;
            o_data = tgt ? bus3.hrdata : bus0.hrdata;
            if (active) begin
               if (cur.err) begin
                  e_rdy = (ph == 1); e_resp = 1'b1; e_data = 32'h0;
               end else begin
                  e_rdy = (ph == cur.ws); e_resp = 1'b0; e_data = cur.rd ? cur.data : 32'h0;
               end
               chk("hreadyout", 32'(o_rdy), 32'(e_rdy));
               chk("hresp", 32'(o_resp), 32'(e_resp));
               chk("hrdata", o_data, e_data);
               if (!o_rdy) lowcnt++;
               ph++;
               if (e_rdy) begin
                  active = 0; last_rd = o_data; last_resp = o_resp; last_low = lowcnt;
                  $display("xfer dut%0d %s addr=%h resp=%0d rdata=%h waits=%0d",
                           tgt ? 3 : 0, cur.rd ? "RD" : "WR", cur.addr, o_resp, o_data, lowcnt);
               end
            end else begin
               chk("idle_bus", {o_data[29:0], o_rdy, o_resp}, 32'h2);
            end
            chk("other_idle", tgt ? {bus0.hrdata[29:0], bus0.hreadyout, bus0.hresp}
                                  : {bus3.hrdata[29:0], bus3.hreadyout, bus3.hresp}, 32'h2);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish expected finish before 1ms");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] old;
      tgt = 1'b0; b_hsel = 1'b0; b_hwrite = 1'b0; b_hmastlock = 1'b0;
      b_haddr = '0; b_hwdata = '0; b_htrans = HTRANS_IDLE;
      b_hsize = HSIZE_WORD; b_hburst = '0; b_hprot = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_rdy0", 32'(bus0.hreadyout), 32'h1);
      chk("rst_resp0", 32'(bus0.hresp), 32'h0);
      chk("rst_data0", bus0.hrdata, 32'h0);
      chk("rst_rdy3", 32'(bus3.hreadyout), 32'h1);
      chk("rst_resp3", 32'(bus3.hresp), 32'h0);
      chk("rst_data3", bus3.hrdata, 32'h0);

      for (int t = 0; t < 2; t++) begin
         tgt = t[0];
         for (int i = 0; i < 64; i++) xfer(1'b1, 2, 32'(i * 4), $urandom(), 1'b1);
         xfer(1'b1, 2, 32'hFFC, $urandom(), 1'b1);
         drain();
         idle(2);
      end

      tgt = 1'b0;
      xfer(1'b1, 2, 32'h10, 32'hDEAD_BEEF, 1'b1);
      xfer(1'b0, 2, 32'h10, 32'h0, 1'b1);
      drain();
      chk("word_rd", last_rd, 32'hDEAD_BEEF);
      chk("word_rd_waits", 32'(last_low), 32'h0);
      xfer(1'b1, 2, 32'h10, 32'h1122_3344, 1'b1);
      xfer(1'b1, 0, 32'h13, 32'hAA00_0000, 1'b1);
      drain();
      idle(2);
      xfer(1'b0, 2, 32'h10, 32'h0, 1'b1);
      drain();
      chk("byte_lane3", last_rd, 32'hAA22_3344);
      xfer(1'b1, 2, 32'h20, 32'h0, 1'b1);
      drain();
      xfer(1'b1, 2, 32'h20, 32'h1234_5678, 1'b1);
      xfer(1'b0, 2, 32'h20, 32'h0, 1'b1);
      drain();
      chk("raw_word", last_rd, 32'h1234_5678);
      xfer(1'b1, 1, 32'h22, 32'hBEEF_0000, 1'b1);
      xfer(1'b0, 2, 32'h20, 32'h0, 1'b1);
      drain();
      chk("raw_half", last_rd, 32'hBEEF_5678);
      xfer(1'b0, 2, 32'h02, 32'h0, 1'b1);
      drain();
      chk("misalign_resp", 32'(last_resp), 32'h1);
      chk("misalign_low", 32'(last_low), 32'h1);
      xfer(1'b1, 2, 32'(MEM_BYTES), 32'hFFFF_FFFF, 1'b1);
      drain();
      chk("oor_resp", 32'(last_resp), 32'h1);
      xfer(1'b1, 1, 32'h31, 32'hFFFF_FFFF, 1'b1);
      xfer(1'b0, 2, 32'h0, 32'h0, 1'b1);
      xfer(1'b0, 2, 32'h30, 32'h0, 1'b1);
      drain();
      xfer(1'b1, 2, 32'hFFC, 32'hCAFE_F00D, 1'b1);
      xfer(1'b0, 2, 32'hFFC, 32'h0, 1'b1);
      drain();
      chk("last_word", last_rd, 32'hCAFE_F00D);
      rand_ops(150);
      drain();
      idle(2);

      tgt = 1'b1;
      xfer(1'b1, 2, 32'h10, 32'h0BAD_F00D, 1'b1);
      xfer(1'b0, 2, 32'h10, 32'h0, 1'b1);
      drain();
      chk("ws3_data", last_rd, 32'h0BAD_F00D);
      chk("ws3_low", 32'(last_low), 32'h3);
      xfer(1'b0, 3, 32'h10, 32'h0, 1'b1);
      drain();
      chk("hsize3_resp", 32'(last_resp), 32'h1);
      xfer(1'b0, 2, 32'hFFFF_FFF0, 32'h0, 1'b1);
      drain();
      chk("below_base_resp", 32'(last_resp), 32'h1);
      old = mdl_word(1, 32'h40);
      xfer(1'b1, 2, 32'h40, ~old, 1'b0);
      rst = 1'b1; b_hsel = 1'b0; b_htrans = HTRANS_IDLE;
      next_cycle();
      rst = 1'b0;
      chk("midrst_rdy", 32'(bus3.hreadyout), 32'h1);
      chk("midrst_resp", 32'(bus3.hresp), 32'h0);
      xfer(1'b0, 2, 32'h40, 32'h0, 1'b1);
      drain();
      chk("midrst_old", last_rd, old);
      rand_ops(150);
      drain();
      idle(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
